seq_adder_sub: RTL and testbench

SEQ_ADDER_SUB -- requirements
Module: seq_adder_sub

---
 rtl/seq_adder_sub.sv | 96 +++++++++
 tb/tb_seq_adder_sub.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_sub.sv
// seq_adder_sub: multi-cycle add/subtract that processes CHUNK bits per clock.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           request an operation (sampled only while idle)
//   a, b, cin, sub  operands, carry/borrow-in and mode (0 = a+b+cin, 1 = a-b-cin)
//   busy, done      not-idle flag and one-cycle completion pulse
//   sum, cout, ovf  registered result, MSB carry-out (1 = no borrow) and signed overflow
module seq_adder_sub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("seq_adder_sub: CHUNK must be at least 1");
        end else if (WIDTH % CHUNK != 0) begin : g_bad_width
            $error("seq_adder_sub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] opa, opb, res, res_n;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [CHUNK:0]   csum;
    logic             cmsb;
    int               idx;

    // Subtraction is a + ~b + ~cin, so the operand and carry are inverted at capture
    // and the datapath is a plain adder. The carry into the top bit of a chunk is
    // recovered from its sum bit, which gives the carry into the MSB on the last chunk.
    always_comb begin
        idx = int'(cnt) * CHUNK;
        csum = {1'b0, opa[idx +: CHUNK]} + {1'b0, opb[idx +: CHUNK]} + {{CHUNK{1'b0}}, carry};
        cmsb = csum[CHUNK-1] ^ opa[idx + CHUNK - 1] ^ opb[idx + CHUNK - 1];
        res_n = res;
        res_n[idx +: CHUNK] = csum[CHUNK-1:0];
    end

    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
        state_n = (state == IDLE) ? (start ? RUN : IDLE) :
                  (state == RUN)  ? ((cnt == LAST) ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                opa   <= a;
                opb   <= sub ? ~b : b;
                carry <= sub ? ~cin : cin;
                cnt   <= '0;
            end
            if (state == RUN) begin
                res   <= res_n;
                carry <= csum[CHUNK];
                cnt   <= cnt + 1'b1;
                if (cnt == LAST) begin
                    sum  <= res_n;
                    cout <= csum[CHUNK];
                    ovf  <= cmsb ^ csum[CHUNK];
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_adder_sub.sv
// tb_seq_adder_sub: scoreboard bench for seq_adder_sub (8/4 main, plus 16/4 and 8/8 latency cases).
module tb_seq_adder_sub;
    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    logic       start88 = 1'b0, cin88 = 1'b0, sub88 = 1'b0;
    logic [7:0] a88 = '0, b88 = '0;
    logic       busy88, done88, cout88, ovf88;
    logic [7:0] sum88;

    int   n_vec = 0;
    int   n_err = 0;
    res_t sbq[$];
    res_t last = '0;

    always #5 clk = ~clk;

    seq_adder_sub #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    seq_adder_sub #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    seq_adder_sub #(.WIDTH(8), .CHUNK(8)) dut88 (
        .clk(clk), .rst(rst), .start(start88), .a(a88), .b(b88), .cin(cin88), .sub(sub88),
        .busy(busy88), .done(done88), .sum(sum88), .cout(cout88), .ovf(ovf88)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic; overflow from the true signed result range.
    function automatic res_t model(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                                   input logic is);
        logic [8:0] w;
        int         r;
        if (is) begin
            w = {1'b0, ia} - {1'b0, ib} - {8'd0, ic};
            model.c = ~w[8];
            r = int'($signed(ia)) - int'($signed(ib)) - int'(ic);
        end else begin
            w = {1'b0, ia} + {1'b0, ib} + {8'd0, ic};
            model.c = w[8];
            r = int'($signed(ia)) + int'($signed(ib)) + int'(ic);
        end
        model.s = w[7:0];
        model.v = (r > 127) || (r < -128);
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                res_t e;
                e = sbq.pop_front();
                check("sum", 32'(sum), 32'(e.s));
                check("cout", 32'(cout), 32'(e.c));
                check("ovf", 32'(ovf), 32'(e.v));
            end
        end
    end

    // Called between edges; returns at posedge+1 with the block back in IDLE.
    task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic is,
                      input bit poke);
        int   n;
        bit   got;
        res_t e;
        e = model(ia, ib, ic, is);
        a = ia;
        b = ib;
        cin = ic;
        sub = is;
        start = 1'b1;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        check("accept_busy", 32'(busy), 32'd1);
        n = 0;
        got = 0;
        while (!got && n < 10) begin
            @(posedge clk);
            n++;
            #1;
            if (done) begin
                got = 1;
            end else begin
                check("run_busy", 32'(busy), 32'd1);
                check("run_hold", 32'(sum), 32'(last.s));
            end
            if (poke) begin
                start = 1'b1;
                a = 8'($urandom);
                b = 8'($urandom);
                sub = 1'($urandom);
            end
        end
        check("latency", 32'(n), 32'd2);
        check("done_busy", 32'(busy), 32'd1);
        last = e;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        start = 1'b1;
        a = 8'h11;
        b = 8'h22;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        op(8'h01, 8'h08, 1'b0, 1'b0, 0);
        op(8'h81, 8'h80, 1'b1, 1'b0, 0);
        op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        op(8'h05, 8'h07, 1'b0, 1'b1, 0);
        op(8'h80, 8'h01, 1'b0, 1'b1, 0);
        op(8'h3C, 8'hA5, 1'b1, 1'b1, 1);
        op(8'hFF, 8'hFF, 1'b1, 1'b0, 1);

        a = 8'h55;
        b = 8'h66;
        cin = 1'b0;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        last = '0;
        repeat (4) @(posedge clk);
        #1;
        op(8'h01, 8'h01, 1'b1, 1'b0, 0);

        for (int i = 0; i < 30; i++)
            op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        a16 = 16'hFFFF;
        b16 = 16'h0001;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        n = 0;
        while (!done16 && n < 10) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("lat16", 32'(n), 32'd4);
        check("sum16", 32'(sum16), 32'h0000);
        check("cout16", 32'(cout16), 32'd1);
        check("ovf16", 32'(ovf16), 32'd0);

        a88 = 8'h81;
        b88 = 8'h80;
        cin88 = 1'b1;
        start88 = 1'b1;
        @(posedge clk);
        #1;
        start88 = 1'b0;
        n = 0;
        while (!done88 && n < 10) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("lat88", 32'(n), 32'd1);
        check("sum88", 32'(sum88), 32'h02);
        check("cout88", 32'(cout88), 32'd1);
        check("ovf88", 32'(ovf88), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
